// File: rtl/obi_copy_dma.sv
// Single-channel OBI word-copy DMA: read one word, write it, repeat len times.
// Define OBI_COPY_DMA_ERR_ABORT_EN to stop the copy on the first bus error.
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   1
    };

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic        a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module obi_copy_dma #(
    parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
    parameter type obi_req_t = logic,
    parameter type obi_rsp_t = logic,
    parameter int unsigned LenWidth = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [ObiCfg.AddrWidth-1:0] src_addr_i,
    input  logic [ObiCfg.AddrWidth-1:0] dst_addr_i,
    input  logic [LenWidth-1:0]         len_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output obi_req_t                    obi_req_o,
    input  obi_rsp_t                    obi_rsp_i
);

    localparam int unsigned AW = ObiCfg.AddrWidth;
    localparam int unsigned DW = ObiCfg.DataWidth;
    localparam int unsigned IW = ObiCfg.IdWidth;
    localparam logic [AW-1:0] Step = AW'(DW / 8);

`ifdef OBI_COPY_DMA_ERR_ABORT_EN
    localparam bit AbortEn = 1'b1;
`else
    localparam bit AbortEn = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            we;
        logic [DW/8-1:0] be;
        logic [DW-1:0]   wdata;
        logic [IW-1:0]   aid;
        logic            a_optional;
    } a_chan_t;

    typedef struct packed {
        a_chan_t a;
        logic    req;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic [IW-1:0] rid;
        logic          err;
        logic          r_optional;
    } r_chan_t;

    typedef struct packed {
        logic    gnt;
        logic    rvalid;
        r_chan_t r;
    } rsp_t;

    localparam int unsigned ReqW    = $bits(req_t);
    localparam int unsigned ReqOutW = $bits(obi_req_t);
    localparam int unsigned RspW    = $bits(rsp_t);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_src;
    logic [AW-1:0]       r_dst;
    logic [AW-1:0]       r_addr;
    logic [LenWidth-1:0] r_cnt;
    logic [DW-1:0]       r_data;
    logic                r_req;
    logic                r_we;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    req_t                w_req;
    rsp_t                w_rsp;
    logic                w_unused_rsp;

    // Casts let the bus types be anything of compatible layout.
    assign w_rsp = rsp_t'(RspW'(obi_rsp_i));
    assign w_unused_rsp = ^{w_rsp.r.rid, w_rsp.r.r_optional};

    always_comb begin
        w_req              = '0;
        w_req.req          = r_req;
        w_req.a.addr       = r_addr;
        w_req.a.we         = r_we;
        w_req.a.be         = '1;
        w_req.a.wdata      = r_data;
        w_req.a.aid        = '0;
        w_req.a.a_optional = 1'b0;
    end

    assign obi_req_o = obi_req_t'(ReqOutW'(ReqW'(w_req)));
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_err <= 1'b0;
                        if (len_i != '0) begin
                            r_src   <= src_addr_i;
                            r_dst   <= dst_addr_i;
                            r_cnt   <= len_i;
                            r_addr  <= src_addr_i;
                            r_we    <= 1'b0;
                            r_req   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_RD_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (w_rsp.gnt) begin
                        r_req   <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (w_rsp.rvalid) begin
                        r_data <= w_rsp.r.rdata;
                        if (w_rsp.r.err) begin
                            r_err <= 1'b1;
                        end
                        if (AbortEn && w_rsp.r.err) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_dst;
                            r_we    <= 1'b1;
                            r_req   <= 1'b1;
                            r_state <= S_WR_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (w_rsp.gnt) begin
                        r_req   <= 1'b0;
                        r_state <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (w_rsp.rvalid) begin
                        if (w_rsp.r.err) begin
                            r_err <= 1'b1;
                        end
                        r_cnt <= r_cnt - LenWidth'(1);
                        r_src <= r_src + Step;
                        r_dst <= r_dst + Step;
                        if ((AbortEn && w_rsp.r.err) ||
                            r_cnt == LenWidth'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_src + Step;
                            r_we    <= 1'b0;
                            r_req   <= 1'b1;
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
